dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter_if.sv | 53 +++++
 rtl/dm_arbiter.sv | 139 +++++++++++++
 tb/tb_dm_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_if.sv
// Bundle of the two requester ports and the shared data-memory port.
//
// Handshake: a requester raises mX_req together with mX_wr/mX_op/mX_addr/
// mX_wdata and holds all of them stable until it sees mX_gnt=1 in the same
// cycle. The access is accepted in the cycle where req and gnt are both high.
// Reads return later as a one-cycle mX_rvalid pulse with mX_rdata. dm_w/dm_r
// are one-cycle strobes that qualify dm_op/dm_addr/dm_wdata in the grant cycle.
interface dm_arbiter_if;
    logic        m0_req;
    logic        m0_wr;
    logic [2:0]  m0_op;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_wr;
    logic [2:0]  m1_op;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;

    logic        dm_w;
    logic        dm_r;
    logic [2:0]  dm_op;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    // Arbiter side.
    modport slave (
        input  m0_req, m0_wr, m0_op, m0_addr, m0_wdata,
        input  m1_req, m1_wr, m1_op, m1_addr, m1_wdata,
        input  dm_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output dm_w, dm_r, dm_op, dm_addr, dm_wdata
    );

    // Environment side: both requesters plus the memory read-data source.
    modport master (
        output m0_req, m0_wr, m0_op, m0_addr, m0_wdata,
        output m1_req, m1_wr, m1_op, m1_addr, m1_wdata,
        output dm_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  dm_w, dm_r, dm_op, dm_addr, dm_wdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-requester arbiter for a single data-memory/peripheral port.
// m0 (CPU) has priority; m1 (DMA/debug) is forced through after
// STARVE_LIMIT consecutive m0 grants while it waits. Writes complete in the
// grant cycle; a read blocks the port until its data returns RD_LAT cycles
// after the grant, and the response pulse coincides with the port being free.
module dm_arbiter #(
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    dm_arbiter_if.slave     bus,
    output logic            dbg_state
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        RWAIT = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  lat_cnt, lat_cnt_nxt;
    logic        owner, owner_nxt;          // 0 = m0, 1 = m1
    logic [3:0]  starve_cnt, starve_nxt;
    logic        gnt0, gnt1;
    logic        force_m1;
    logic        rd_done;                   // last wait cycle: capture read data
    logic        m0_rvalid_q, m1_rvalid_q;
    logic [31:0] m0_rdata_q, m1_rdata_q;

    assign dbg_state = state;
    assign force_m1  = (starve_cnt == 4'(STARVE_LIMIT));

    // Arbitration: grants only in IDLE and never while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst && state == IDLE) begin
            if (bus.m0_req && bus.m1_req) begin
                if (force_m1) gnt1 = 1'b1;
                else          gnt0 = 1'b1;
            end else if (bus.m0_req) begin
                gnt0 = 1'b1;
            end else if (bus.m1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Next-state logic: a read grant opens a wait of RD_LAT cycles.
    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        owner_nxt   = owner;
        rd_done     = 1'b0;
        case (state)
            IDLE: begin
                if ((gnt0 && !bus.m0_wr) || (gnt1 && !bus.m1_wr)) begin
                    state_nxt   = RWAIT;
                    lat_cnt_nxt = 3'(RD_LAT);
                    owner_nxt   = gnt1;
                end
            end
            RWAIT: begin
                if (lat_cnt == 3'd1) begin
                    rd_done     = 1'b1;
                    state_nxt   = IDLE;
                    lat_cnt_nxt = 3'd0;
                end else begin
                    lat_cnt_nxt = lat_cnt - 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Starvation counter: counts m0 wins over a waiting m1, saturating.
    always_comb begin
        starve_nxt = starve_cnt;
        if (!bus.m1_req || gnt1) begin
            starve_nxt = 4'd0;
        end else if (gnt0 && !force_m1) begin
            starve_nxt = starve_cnt + 4'd1;
        end
    end

    // Shared-port drive: winner's fields in the grant cycle, zero otherwise.
    always_comb begin
        bus.dm_w     = 1'b0;
        bus.dm_r     = 1'b0;
        bus.dm_op    = 3'd0;
        bus.dm_addr  = 32'd0;
        bus.dm_wdata = 32'd0;
        if (gnt0) begin
            bus.dm_w     = bus.m0_wr;
            bus.dm_r     = !bus.m0_wr;
            bus.dm_op    = bus.m0_op;
            bus.dm_addr  = bus.m0_addr;
            bus.dm_wdata = bus.m0_wdata;
        end else if (gnt1) begin
            bus.dm_w     = bus.m1_wr;
            bus.dm_r     = !bus.m1_wr;
            bus.dm_op    = bus.m1_op;
            bus.dm_addr  = bus.m1_addr;
            bus.dm_wdata = bus.m1_wdata;
        end
    end

    // State, counters, captured read data and response pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            lat_cnt     <= 3'd0;
            owner       <= 1'b0;
            starve_cnt  <= 4'd0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= 32'd0;
            m1_rdata_q  <= 32'd0;
        end else begin
            state       <= state_nxt;
            lat_cnt     <= lat_cnt_nxt;
            owner       <= owner_nxt;
            starve_cnt  <= starve_nxt;
            m0_rvalid_q <= rd_done && !owner;
            m1_rvalid_q <= rd_done && owner;
            if (rd_done && !owner) m0_rdata_q <= bus.dm_rdata;
            if (rd_done && owner)  m1_rdata_q <= bus.dm_rdata;
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_rvalid = m0_rvalid_q;
    assign bus.m1_rvalid = m1_rvalid_q;
    assign bus.m0_rdata  = m0_rdata_q;
    assign bus.m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: three instances (RD_LAT=1/2/3, STARVE_LIMIT=4/4/1)
// share one stimulus stream. A cycle-level model built on completion-cycle
// arithmetic is compared against every output of every instance on each
// falling edge; directed scenarios add hand-computed literal expectations.
module tb_dm_arbiter;

    localparam int N = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [2:0]  m0_op, m1_op;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, dm_rdata;

    // ---------------- per-instance observed outputs ----------------
    logic        o_m0_gnt [N];
    logic        o_m1_gnt [N];
    logic        o_m0_rv  [N];
    logic        o_m1_rv  [N];
    logic [31:0] o_m0_rd  [N];
    logic [31:0] o_m1_rd  [N];
    logic        o_dm_w   [N];
    logic        o_dm_r   [N];
    logic [2:0]  o_dm_op  [N];
    logic [31:0] o_dm_addr[N];
    logic [31:0] o_dm_wd  [N];
    logic        o_state  [N];

    for (genvar g = 0; g < N; g++) begin : gen_dut
        dm_arbiter_if bus ();
        assign bus.m0_req   = m0_req;
        assign bus.m0_wr    = m0_wr;
        assign bus.m0_op    = m0_op;
        assign bus.m0_addr  = m0_addr;
        assign bus.m0_wdata = m0_wdata;
        assign bus.m1_req   = m1_req;
        assign bus.m1_wr    = m1_wr;
        assign bus.m1_op    = m1_op;
        assign bus.m1_addr  = m1_addr;
        assign bus.m1_wdata = m1_wdata;
        assign bus.dm_rdata = dm_rdata;
        assign o_m0_gnt[g]  = bus.m0_gnt;
        assign o_m1_gnt[g]  = bus.m1_gnt;
        assign o_m0_rv[g]   = bus.m0_rvalid;
        assign o_m1_rv[g]   = bus.m1_rvalid;
        assign o_m0_rd[g]   = bus.m0_rdata;
        assign o_m1_rd[g]   = bus.m1_rdata;
        assign o_dm_w[g]    = bus.dm_w;
        assign o_dm_r[g]    = bus.dm_r;
        assign o_dm_op[g]   = bus.dm_op;
        assign o_dm_addr[g] = bus.dm_addr;
        assign o_dm_wd[g]   = bus.dm_wdata;

        dm_arbiter #(
            .RD_LAT      (g + 1),
            .STARVE_LIMIT((g == 2) ? 1 : 4)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .bus      (bus),
            .dbg_state(o_state[g])
        );
    end

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;
    logic [0:0] exp_q[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model + compare process ----------------
    int          cyc;
    bit          pend  [N];
    int          done  [N];   // cycle in which the read response is due
    int          own   [N];
    int          starve[N];
    logic [31:0] rd0   [N];
    logic [31:0] rd1   [N];

    initial begin
        int lat, lim, win;
        bit busy, rv0, rv1, ew, er;
        logic [2:0]  eop;
        logic [31:0] ea, ewd;
        string p;
        cyc = 0;
        for (int k = 0; k < N; k++) begin
            pend[k] = 0; done[k] = 0; own[k] = 0; starve[k] = 0;
            rd0[k] = 32'd0; rd1[k] = 32'd0;
        end
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                lat  = k + 1;
                lim  = (k == 2) ? 1 : 4;
                busy = pend[k] && (cyc < done[k]);
                rv0  = pend[k] && (cyc == done[k]) && (own[k] == 0);
                rv1  = pend[k] && (cyc == done[k]) && (own[k] == 1);
                win  = -1;
                if (rst && !busy) begin
                    if (m0_req && m1_req) win = (starve[k] == lim) ? 1 : 0;
                    else if (m0_req)      win = 0;
                    else if (m1_req)      win = 1;
                end
                ew = 0; er = 0; eop = 3'd0; ea = 32'd0; ewd = 32'd0;
                if (win == 0) begin
                    ew = m0_wr; er = !m0_wr; eop = m0_op; ea = m0_addr; ewd = m0_wdata;
                end else if (win == 1) begin
                    ew = m1_wr; er = !m1_wr; eop = m1_op; ea = m1_addr; ewd = m1_wdata;
                end
                p = $sformatf("u%0d c%0d ", k, cyc);
                chk1 ({p, "m0_gnt"},    o_m0_gnt[k],  win == 0);
                chk1 ({p, "m1_gnt"},    o_m1_gnt[k],  win == 1);
                chk1 ({p, "m0_rvalid"}, o_m0_rv[k],   rv0);
                chk1 ({p, "m1_rvalid"}, o_m1_rv[k],   rv1);
                chk32({p, "m0_rdata"},  o_m0_rd[k],   rd0[k]);
                chk32({p, "m1_rdata"},  o_m1_rd[k],   rd1[k]);
                chk1 ({p, "dm_w"},      o_dm_w[k],    ew);
                chk1 ({p, "dm_r"},      o_dm_r[k],    er);
                chk32({p, "dm_op"},     32'(o_dm_op[k]), 32'(eop));
                chk32({p, "dm_addr"},   o_dm_addr[k], ea);
                chk32({p, "dm_wdata"},  o_dm_wd[k],   ewd);
                chk1 ({p, "state"},     o_state[k],   busy);
                // advance the model across the coming rising edge
                if (!rst) begin
                    pend[k] = 0; starve[k] = 0; rd0[k] = 32'd0; rd1[k] = 32'd0;
                end else begin
                    if (pend[k] && cyc == done[k] - 1) begin
                        if (own[k] == 0) rd0[k] = dm_rdata;
                        else             rd1[k] = dm_rdata;
                    end
                    if (pend[k] && cyc >= done[k]) pend[k] = 0;
                    if (!m1_req || win == 1)                  starve[k] = 0;
                    else if (win == 0 && starve[k] < lim)     starve[k] = starve[k] + 1;
                    if ((win == 0 && !m0_wr) || (win == 1 && !m1_wr)) begin
                        pend[k] = 1; done[k] = cyc + lat + 1; own[k] = win;
                    end
                end
            end
            cyc++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_wr = 1'(($urandom_range(0, 1))); m0_op = 3'($urandom_range(0, 7));
        m0_addr = $urandom; m0_wdata = $urandom;
        m1_req = 1'b0; m1_wr = 1'(($urandom_range(0, 1))); m1_op = 3'($urandom_range(0, 7));
        m1_addr = $urandom; m1_wdata = $urandom;
        dm_rdata = $urandom;
    endtask

    task automatic set_m0(input logic req, input logic wr, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata);
        m0_req = req; m0_wr = wr; m0_op = op; m0_addr = addr; m0_wdata = wdata;
    endtask

    task automatic set_m1(input logic req, input logic wr, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata);
        m1_req = req; m1_wr = wr; m1_op = op; m1_addr = addr; m1_wdata = wdata;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [0:0] e;
        rst = 1'b0;
        idle_inputs();
        set_m0(1'b1, 1'b1, 3'd2, 32'h55, 32'h1);   // request held during reset
        tick(); mid();
        for (int k = 0; k < N; k++) begin
            chk1 ($sformatf("rst u%0d m0_gnt", k),   o_m0_gnt[k], 1'b0);
            chk1 ($sformatf("rst u%0d dm_w", k),     o_dm_w[k],   1'b0);
            chk32($sformatf("rst u%0d dm_addr", k),  o_dm_addr[k], 32'h0);
            chk1 ($sformatf("rst u%0d m0_rvalid", k), o_m0_rv[k], 1'b0);
            chk32($sformatf("rst u%0d m0_rdata", k), o_m0_rd[k],  32'h0);
            chk1 ($sformatf("rst u%0d state", k),    o_state[k],  1'b0);
        end
        tick(); mid();
        tick(); rst = 1'b1; idle_inputs(); mid();
        repeat (2) begin tick(); mid(); end

        // m0 single read, data returns RD_LAT cycles later
        tick(); set_m0(1'b1, 1'b0, 3'd2, 32'h10, 32'h0); mid();
        chk1 ("s1 u0 m0_gnt", o_m0_gnt[0], 1'b1);
        chk1 ("s1 u0 m1_gnt", o_m1_gnt[0], 1'b0);
        chk1 ("s1 u0 dm_r",   o_dm_r[0],   1'b1);
        chk1 ("s1 u0 dm_w",   o_dm_w[0],   1'b0);
        chk32("s1 u0 dm_addr", o_dm_addr[0], 32'h10);
        chk32("s1 u0 dm_op",  32'(o_dm_op[0]), 32'd2);
        tick(); idle_inputs(); dm_rdata = 32'hDEADBEEF; mid();
        chk1 ("s1 u0 busy",      o_state[0], 1'b1);
        chk1 ("s1 u0 rvalid t1", o_m0_rv[0], 1'b0);
        tick(); dm_rdata = 32'h11112222; mid();
        chk1 ("s1 u0 rvalid t2", o_m0_rv[0], 1'b1);
        chk32("s1 u0 rdata",     o_m0_rd[0], 32'hDEADBEEF);
        chk1 ("s1 u0 m1_rvalid", o_m1_rv[0], 1'b0);
        chk32("s1 u0 m1_rdata",  o_m1_rd[0], 32'h0);
        chk1 ("s1 u1 rvalid t2", o_m0_rv[1], 1'b0);
        tick(); dm_rdata = 32'h33334444; mid();
        chk1 ("s1 u0 rvalid t3", o_m0_rv[0], 1'b0);
        chk32("s1 u0 rdata hold", o_m0_rd[0], 32'hDEADBEEF);
        chk1 ("s1 u1 rvalid t3", o_m0_rv[1], 1'b1);
        chk32("s1 u1 rdata",     o_m0_rd[1], 32'h11112222);
        tick(); dm_rdata = $urandom; mid();
        chk1 ("s1 u2 rvalid t4", o_m0_rv[2], 1'b1);
        chk32("s1 u2 rdata",     o_m0_rd[2], 32'h33334444);
        repeat (3) begin tick(); idle_inputs(); mid(); end

        // both masters write every cycle: starvation rotation
        exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            tick();
            set_m0(1'b1, 1'b1, 3'd2, 32'h100, 32'hA0A0A0A0);
            set_m1(1'b1, 1'b1, 3'd1, 32'h200, 32'h5B5B5B5B);
            mid();
            e = exp_q.pop_front();
            chk1 ($sformatf("s2 u0 m0_gnt %0d", i), o_m0_gnt[0], !e);
            chk1 ($sformatf("s2 u0 m1_gnt %0d", i), o_m1_gnt[0], e);
            chk1 ($sformatf("s2 u0 dm_w %0d", i),   o_dm_w[0],   1'b1);
            chk32($sformatf("s2 u0 dm_addr %0d", i), o_dm_addr[0], e ? 32'h200 : 32'h100);
            chk32($sformatf("s2 u0 dm_wdata %0d", i), o_dm_wd[0], e ? 32'h5B5B5B5B : 32'hA0A0A0A0);
            chk1 ($sformatf("s2 u2 m1_gnt %0d", i), o_m1_gnt[2], 1'(i % 2));
        end
        repeat (3) begin tick(); idle_inputs(); mid(); end

        // m1 read with RD_LAT=3 while m0 arrives one cycle later
        tick(); set_m1(1'b1, 1'b0, 3'd4, 32'h240, 32'h0); mid();
        chk1 ("s3 u2 m1_gnt", o_m1_gnt[2], 1'b1);
        chk32("s3 u2 dm_addr", o_dm_addr[2], 32'h240);
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i == 1) begin
                idle_inputs();
                set_m0(1'b1, 1'b1, 3'd2, 32'h300, 32'h77777777);
            end
            if (i == 3) dm_rdata = 32'hCAFE0003;
            else        dm_rdata = $urandom;
            mid();
            chk1 ($sformatf("s3 u2 m0_gnt t%0d", i), o_m0_gnt[2], 1'b0);
            chk1 ($sformatf("s3 u2 m1_gnt t%0d", i), o_m1_gnt[2], 1'b0);
            chk1 ($sformatf("s3 u2 dm_w t%0d", i),   o_dm_w[2],   1'b0);
        end
        tick(); dm_rdata = $urandom; mid();
        chk1 ("s3 u2 m1_rvalid", o_m1_rv[2], 1'b1);
        chk32("s3 u2 m1_rdata",  o_m1_rd[2], 32'hCAFE0003);
        chk1 ("s3 u2 m0_gnt",    o_m0_gnt[2], 1'b1);
        chk32("s3 u2 dm_addr",   o_dm_addr[2], 32'h300);
        repeat (4) begin tick(); idle_inputs(); mid(); end

        // reset one cycle after a read grant abandons the read
        tick(); set_m0(1'b1, 1'b0, 3'd2, 32'h80, 32'h0); mid();
        chk1 ("s4 u1 m0_gnt", o_m0_gnt[1], 1'b1);
        tick(); idle_inputs(); rst = 1'b0;
        set_m1(1'b1, 1'b1, 3'd2, 32'h400, 32'h12345678); dm_rdata = 32'h99999999; mid();
        for (int k = 0; k < N; k++) begin
            chk1($sformatf("s4 u%0d dm_w rst", k), o_dm_w[k], 1'b0);
            chk1($sformatf("s4 u%0d dm_r rst", k), o_dm_r[k], 1'b0);
        end
        tick(); rst = 1'b1; dm_rdata = 32'h88888888; mid();
        chk1 ("s4 u1 m1_gnt",    o_m1_gnt[1], 1'b1);
        chk1 ("s4 u1 dm_w",      o_dm_w[1],   1'b1);
        chk32("s4 u1 dm_addr",   o_dm_addr[1], 32'h400);
        chk1 ("s4 u1 m0_rvalid", o_m0_rv[1],  1'b0);
        chk32("s4 u1 m0_rdata",  o_m0_rd[1],  32'h0);
        chk1 ("s4 u0 m0_rvalid", o_m0_rv[0],  1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(); idle_inputs(); mid();
            chk1($sformatf("s4 u1 no m0_rvalid %0d", i), o_m0_rv[1], 1'b0);
            chk1($sformatf("s4 u1 no m1_rvalid %0d", i), o_m1_rv[1], 1'b0);
        end
        // grants stay gated for the whole reset with both requests up
        tick(); rst = 1'b0;
        set_m0(1'b1, 1'b1, 3'd2, 32'h90, 32'h1); set_m1(1'b1, 1'b1, 3'd2, 32'h94, 32'h2);
        for (int i = 0; i < 2; i++) begin
            if (i == 1) tick();
            mid();
            for (int k = 0; k < N; k++) begin
                chk1($sformatf("s4 u%0d gated m0 %0d", k, i), o_m0_gnt[k], 1'b0);
                chk1($sformatf("s4 u%0d gated m1 %0d", k, i), o_m1_gnt[k], 1'b0);
                chk1($sformatf("s4 u%0d gated w %0d", k, i),  o_dm_w[k],   1'b0);
            end
        end
        tick(); rst = 1'b1; mid();
        chk1("s4 u0 first m0_gnt", o_m0_gnt[0], 1'b1);
        tick(); idle_inputs(); mid();

        // idle bus: everything must stay zero whatever the fields carry
        for (int i = 0; i < 10; i++) begin
            tick(); idle_inputs(); mid();
            chk1 ($sformatf("s5 u0 gnt %0d", i),    o_m0_gnt[0] | o_m1_gnt[0], 1'b0);
            chk1 ($sformatf("s5 u0 rvalid %0d", i), o_m0_rv[0] | o_m1_rv[0],   1'b0);
            chk1 ($sformatf("s5 u0 strobe %0d", i), o_dm_w[0] | o_dm_r[0],     1'b0);
            chk32($sformatf("s5 u0 dm_addr %0d", i), o_dm_addr[0], 32'h0);
            chk32($sformatf("s5 u0 dm_wdata %0d", i), o_dm_wd[0], 32'h0);
            chk32($sformatf("s5 u0 dm_op %0d", i),  32'(o_dm_op[0]), 32'h0);
        end
        // m1_req toggling between m0 grants never builds up starvation
        for (int i = 0; i < 12; i++) begin
            tick();
            set_m0(1'b1, 1'b1, 3'd2, 32'h500, 32'hC0C0C0C0);
            set_m1(1'((i % 2) == 0), 1'b1, 3'd2, 32'h600, 32'h0D0D0D0D);
            mid();
            for (int k = 0; k < N; k++) begin
                chk1($sformatf("s5 u%0d toggle m0 %0d", k, i), o_m0_gnt[k], 1'b1);
                chk1($sformatf("s5 u%0d toggle m1 %0d", k, i), o_m1_gnt[k], 1'b0);
            end
        end
        tick(); idle_inputs(); mid();

        // mixed traffic with occasional resets, checked by the model only
        for (int i = 0; i < 200; i++) begin
            tick();
            idle_inputs();
            m0_req = 1'($urandom_range(0, 1));
            m1_req = 1'($urandom_range(0, 1));
            rst    = ($urandom_range(0, 24) != 0);
        end
        tick(); rst = 1'b1; idle_inputs();
        repeat (6) tick();
        mid();
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
